// File: rtl/divider_sched.sv
// divider_sched: programmable tick scheduler. Emits a one-cycle clk_flag
// every 'div' cycles while running, with a ready/valid ratio update that
// takes effect on a period boundary.
// Optional build macro: DIVIDER_SCHED_BURST_EN adds the burst_len port and
// stops ticking after a programmed number of ticks, pulsing done.
//
// state  | meaning
// -------+--------------------------------------------------
// S_IDLE | not ticking; ratio updates apply next cycle
// S_RUN  | ticking, no ratio pending; cfg accepted -> S_PEND
// S_PEND | ticking, new ratio held until the next tick
module divider_sched #(
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             start,
  input  logic             stop,
`ifdef DIVIDER_SCHED_BURST_EN
  input  logic [DIV_W-1:0] burst_len,
`endif
  output logic             clk_flag,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_act_nxt;
  logic [DIV_W-1:0] div_pend;
  logic [DIV_W-1:0] div_pend_nxt;
  logic [DIV_W-1:0] div_m1;
  logic [DIV_W-1:0] cfg_clamped;
  logic             cfg_xfer;
  logic             start_ok;
  logic             tick;
  logic             last_tick;

  // Ratios below 2 cannot produce a distinct tick period, so they are raised to 2.
  assign cfg_clamped = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
  assign div_m1      = div_act - DIV_W'(1);

  assign cfg_ready = (state != S_PEND);
  assign busy      = (state != S_IDLE);
  assign cfg_xfer  = cfg_valid & cfg_ready;
  assign start_ok  = (state == S_IDLE) & start & ~stop;

  // A stop request masks the tick of the same cycle.
  assign tick     = busy & (cnt == div_m1) & ~stop;
  assign clk_flag = tick;

`ifdef DIVIDER_SCHED_BURST_EN
  logic [DIV_W-1:0] burst_act;
  logic [DIV_W-1:0] burst_cnt;

  assign last_tick = tick & (burst_act != '0) & (burst_cnt == burst_act - DIV_W'(1));

  // Burst length is captured on an accepted start; ticks are counted from there.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      burst_act <= '0;
      burst_cnt <= '0;
    end else if (start_ok) begin
      burst_act <= burst_len;
      burst_cnt <= '0;
    end else if (tick) begin
      burst_cnt <= burst_cnt + DIV_W'(1);
    end
  end
`else
  assign last_tick = 1'b0;
`endif

  assign done = last_tick;

  // State, counter and ratio registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      div_act  <= DIV_W'(DIV_RST);
      div_pend <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      div_act  <= div_act_nxt;
      div_pend <= div_pend_nxt;
    end
  end

  // Next-state, counter and ratio update logic.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    div_act_nxt  = div_act;
    div_pend_nxt = div_pend;

    case (state)
      S_IDLE: begin
        if (cfg_xfer) begin
          div_act_nxt = cfg_clamped;
        end
        if (start_ok) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end
      end

      S_RUN, S_PEND: begin
        if (stop) begin
          state_nxt    = S_IDLE;
          cnt_nxt      = '0;
          div_pend_nxt = '0;
        end else begin
          if (cnt == div_m1) begin
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + DIV_W'(1);
          end

          if ((state == S_RUN) && cfg_xfer) begin
            div_pend_nxt = cfg_clamped;
            state_nxt    = S_PEND;
          end

          if ((state == S_PEND) && tick) begin
            div_act_nxt  = div_pend;
            div_pend_nxt = '0;
            state_nxt    = S_RUN;
          end

          // End of burst: return to idle; a ratio accepted on this very
          // cycle goes straight to the active register as it would in idle.
          if (last_tick) begin
            state_nxt    = S_IDLE;
            cnt_nxt      = '0;
            div_pend_nxt = '0;
            if ((state == S_RUN) && cfg_xfer) begin
              div_act_nxt = cfg_clamped;
            end
          end
        end
      end

      default: begin
        state_nxt    = S_IDLE;
        cnt_nxt      = '0;
        div_pend_nxt = '0;
      end
    endcase
  end

endmodule

// File: doc/divider_sched.md
DIVIDER_SCHED -- requirements
Module: divider_sched

Interface
- REQ-001: Parameter DIV_W, default 8; width of the divide ratio and counter.
- REQ-002: Parameter DIV_RST, default 5; divide ratio loaded at reset.
- REQ-003: sys_clk  input  1  sole clock; all logic on rising edge.
- REQ-004: sys_rst  input  1  reset, synchronous, active-high.
- REQ-005: cfg_valid  input  1  new divide ratio offered on cfg_div.
- REQ-006: cfg_ready  output  1  block can accept a ratio; transfer occurs when cfg_valid & cfg_ready.
- REQ-007: cfg_div  input  DIV_W  requested divide ratio.
- REQ-008: start  input  1  one-cycle request to begin ticking.
- REQ-009: stop  input  1  one-cycle request to halt ticking.
- REQ-010: burst_len  input  DIV_W  number of ticks per burst; sampled on start (BURST_EN only).
- REQ-011: clk_flag  output  1  one-cycle tick pulse, once per divide period.
- REQ-012: busy  output  1  high while the block is in RUN or PEND.
- REQ-013: done  output  1  one-cycle pulse on the last tick of a burst (BURST_EN only; otherwise tied 0).

Function
- REQ-014: The FSM SHALL have the states IDLE, RUN (ticking, no ratio pending) and PEND (ticking, new ratio held).
- REQ-015: The active ratio SHALL be clamped, so a cfg_div of 0 or 1 is stored as 2; the range is 2..2^DIV_W-1.
- REQ-016: cfg_ready SHALL be 1 in IDLE and RUN and 0 in PEND.
- REQ-017: A transfer in IDLE SHALL update the active ratio on the next cycle.
- REQ-018: A transfer in RUN SHALL store the ratio as pending and move the FSM to PEND.
- REQ-019: In PEND, the pending ratio SHALL become active in the cycle clk_flag fires, and the FSM SHALL return to RUN.
- REQ-020: The counter SHALL run from 0 to div-1 and then wrap to 0; clk_flag SHALL be 1 exactly in the cycle where cnt==div-1.
- REQ-021: start in IDLE, in cycle t, SHALL enter RUN with cnt=0 at t+1; the first clk_flag SHALL occur at t+div, then every div cycles.
- REQ-022: start in RUN or PEND SHALL be ignored.
- REQ-023: stop in RUN or PEND SHALL move the FSM to IDLE the next cycle, clear cnt and discard any pending ratio.
- REQ-024: clk_flag SHALL be suppressed in the cycle stop is asserted.
- REQ-025: If start and stop are asserted together, stop SHALL win.
- REQ-026: busy SHALL be 0 in IDLE and 1 otherwise; the flag latency from start is exactly div cycles, with no extra pipeline stage.

Reset
- REQ-027: While sys_rst is 1 at a rising edge, the block SHALL enter IDLE, set cnt=0, set the active ratio to DIV_RST, and clear the pending ratio and the burst counter.
- REQ-028: The outputs after reset SHALL be clk_flag=0, done=0, busy=0 and cfg_ready=1.
- REQ-029: Reset SHALL override all other inputs in the same cycle, including mid-period and during PEND.

Configuration
- REQ-030: Macro DIVIDER_SCHED_BURST_EN, when defined, SHALL compile in burst mode.
- REQ-031: With the macro defined, burst_len SHALL be latched on an accepted start; a value of 0 selects continuous ticking.
- REQ-032: With the macro defined and a non-zero burst_len, done SHALL pulse together with the burst_len-th clk_flag, and the FSM SHALL enter IDLE the next cycle.
- REQ-033: With the macro defined, stop SHALL abort a burst without pulsing done.
- REQ-034: Without the macro, the burst_len port SHALL be absent, done SHALL be constant 0, and ticking SHALL be continuous until stop.

Verification
- REQ-035: Reset then idle: with sys_rst=1 for 2 cycles, the bench SHALL see clk_flag=0, busy=0, cfg_ready=1 and done=0; a start with no cfg SHALL give ticks every 5 cycles.
- REQ-036: Basic period: with cfg_div=5 loaded in IDLE and start at cycle 10, the bench SHALL see clk_flag at cycles 15, 20 and 25, each 1 cycle wide.
- REQ-037: Mid-run reconfig: with div=5 and start at 10, and cfg_div=3 accepted at 17, the bench SHALL see cfg_ready=0 from 18, a flag at 20, then flags at 23 and 26, with cfg_ready=1 from 21.
- REQ-038: Stop collision: with div=4, start at 0 and stop at 8 (a tick cycle), the bench SHALL see a flag at 4, no flag at 8, and busy=0 from 9.
- REQ-039: Clamp: with cfg_div=1, the bench SHALL see flags every 2 cycles; with cfg_div=0, the same.
- REQ-040: Burst (macro on): with div=3, burst_len=4 and start at 0, the bench SHALL see flags at 3, 6, 9 and 12, done at 12 only, and busy=0 at 13.
